// File: rtl/mips_ctl_pkg.sv
// Shared constants and types for the multicycle MIPS main controller:
// state encodings, opcodes, aluop codes and the decoded control word.
package mips_ctl_pkg;

  localparam int OP_W = 6;
  localparam int ST_W = 4;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational Moore output decoder: current state -> datapath control word.
module mc_outdec
  import mips_ctl_pkg::*;
(
  input  logic [ST_W-1:0] state,
  output ctrl_t           ctrl
);

  // Per-state control word; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alusrcb = 2'b01;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      DECODE: begin
        ctrl.alusrcb = 2'b11;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      MEMRD: begin
        ctrl.iord = 1'b1;
      end
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_FUNCT;
      end
      RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALU_ADD;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: state register, next-state logic,
// PC enable gate and reset gating of the write enables.
module mc_maindec
  import mips_ctl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  output logic           pcen,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic [1:0]     pcsrc,
  output logic           regdst,
  output logic           memtoreg,
  output logic           badop,
  output logic [STW-1:0] state
);

  logic [STW-1:0] next_state;
  logic           op_bad;
  ctrl_t          ctrl;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; op only matters in DECODE and MEMADR.
  always_comb begin
    next_state = FETCH;
    op_bad     = 1'b0;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default: begin
            next_state = FETCH;
            op_bad     = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (op == OP_LW) begin
          next_state = MEMRD;
        end else if (op == OP_SW) begin
          next_state = MEMWR;
        end else begin
          next_state = FETCH;
        end
      end
      MEMRD:   next_state = MEMWB;
      RTYPEEX: next_state = RTYPEWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  // Write enables are suppressed while reset is held so an aborted
  // instruction cannot complete a partial writeback.
  always_comb begin
    pcen     = ~reset & (ctrl.pcwrite | (ctrl.branch & zero));
    memwrite = ~reset & ctrl.memwrite;
    irwrite  = ~reset & ctrl.irwrite;
    regwrite = ~reset & ctrl.regwrite;
    badop    = ~reset & op_bad;
    iord     = ctrl.iord;
    alusrca  = ctrl.alusrca;
    alusrcb  = ctrl.alusrcb;
    aluop    = ctrl.aluop;
    pcsrc    = ctrl.pcsrc;
    regdst   = ctrl.regdst;
    memtoreg = ctrl.memtoreg;
  end

endmodule
